// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_fa.sv
// Single-bit full-adder cell; the serial subtractor reuses it once per clock.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic co,
    output logic s
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor (a - b as a + ~b + 1), LSB first, one bit per clock.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bo,
    output logic         v
);

    localparam int CW = $clog2(W) + 1;

    state_t         state_reg;
    state_t         state_next;
    logic [W-1:0]   a_sr_reg;
    logic [W-1:0]   b_sr_reg;
    logic [W-1:0]   res_sr_reg;
    logic [W-1:0]   res_shift;
    logic           carry_reg;
    logic           c_msb_in_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   d_reg;
    logic           bo_reg;
    logic           v_reg;
    logic           fa_s;
    logic           fa_co;
    logic           last_bit;

    fa u_fa (
        .a  (a_sr_reg[0]),
        .b  (b_sr_reg[0]),
        .ci (carry_reg),
        .co (fa_co),
        .s  (fa_s)
    );

    // The newest sum bit enters at the MSB so that after W shifts bit 0 is the LSB.
    assign res_shift = {fa_s, res_sr_reg[W-1:1]};
    assign last_bit  = (cnt_reg == CW'(W - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            a_sr_reg     <= '0;
            b_sr_reg     <= '0;
            res_sr_reg   <= '0;
            carry_reg    <= 1'b0;
            c_msb_in_reg <= 1'b0;
            cnt_reg      <= '0;
            d_reg        <= '0;
            bo_reg       <= 1'b0;
            v_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sr_reg  <= a;
                        b_sr_reg  <= ~b;
                        carry_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    res_sr_reg <= res_shift;
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    carry_reg  <= fa_co;
                    cnt_reg    <= cnt_reg + CW'(1);
                    // Carry into the MSB is needed for the signed overflow test.
                    if (cnt_reg == CW'(W - 2)) c_msb_in_reg <= fa_co;
                    if (last_bit) begin
                        d_reg  <= res_shift;
                        bo_reg <= ~fa_co;
                        v_reg  <= c_msb_in_reg ^ fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == RUN) || (state_reg == DONE);
    assign done = (state_reg == DONE);
    assign d    = d_reg;
    assign bo   = bo_reg;
    assign v    = v_reg;

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial W-bit subtractor computing a − b, LSB first, one bit per clock.
- Built around the existing full-adder cell: subtraction is performed as a + ~b + 1.
- It is the inverse-operation companion to the ripple-carry adder path. It trades latency for area: a single full-adder cell is used instead of W of them.
- It is driven by a start/done handshake from a controlling block or bench.

Parameters:
- W, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  W  minuend; captured on the accepting edge
- b  input  W  subtrahend; captured on the accepting edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse in DONE state
- d  output  W  difference a − b mod 2^W; held until next accepted start
- bo  output  1  unsigned borrow out (1 when a < b unsigned)
- v  output  1  signed overflow of a − b (two's complement)

Behaviour:
- Single clock. Reset is synchronous and active-high. All state is updated only on the rising edge of clk.
- Reset effects:
  - state=IDLE.
  - busy=0, done=0, d=0, bo=0, v=0.
  - Internal shift registers cleared; carry register = 0; bit counter = 0.
- Reset dominates start and any in-progress operation. If reset is asserted mid-RUN, the operation is aborted, no done pulse is produced, and outputs return to their reset values at the next edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: capture a into a_sr and ~b into b_sr, set carry=1, set counter=0, go to RUN.
  - start=0 → remain in IDLE.
  - d, bo and v hold their last values.
- RUN, each edge:
  - Compute the full-adder sum s and carry co from (a_sr[0], b_sr[0], carry).
  - Shift s into the MSB of the result register (right shift).
  - Shift a_sr and b_sr right by 1; carry ← co; counter += 1.
  - On the edge processing bit W−2, also save co as c_msb_in, the carry into the MSB.
  - On the edge processing bit W−1 (counter==W−1):
    - d ← final result register contents.
    - bo ← ~co.
    - v ← c_msb_in XOR co.
    - go to DONE.
- DONE: done=1 for exactly one cycle. Next edge → IDLE unconditionally.
- Start handling:
  - start is ignored in RUN and DONE; no queuing.
  - The earliest back-to-back acceptance is the edge after DONE.
- Latency: start accepted at edge 0; bits are processed at edges 1..W; done is high during the cycle following edge W. Throughput is one operation per W+2 cycles.
- Output timing:
  - busy is a registered state decode.
  - done is asserted only in DONE.
  - d/bo/v update only on the transition into DONE.
- Operands a and b may change freely after the accepting edge.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - the default width constant, 4.
- One natural sub-module: the existing fa cell. It is instantiated once for the serial bit-slice, with ports (a, b, ci, co, s).
- The counter width is $clog2(W) + 1, a localparam.

Test Plan:
- Basic subtraction, W=4: reset 2 cycles; a=7, b=3, start 1 cycle → busy for 5 cycles, done pulse in cycle 5 after accept; d=4, bo=0, v=0.
- Borrow: a=3, b=7 → d=4'b1100 (12), bo=1, v=0.
- Signed overflow: a=4'b1000 (−8), b=1 → d=7, bo=0, v=1. Also a=7, b=4'b1111 (−1) → d=8, bo=1, v=1.
- Zero/equal: a=0, b=0 → d=0, bo=0, v=0. Also a=9, b=9 → d=0, bo=0, v=0.
- Start while busy: second start with a=1, b=1 asserted during RUN → ignored; first result is unchanged; exactly one done pulse. A start in the cycle after DONE is accepted.
- Reset mid-operation: a=7, b=3, reset asserted at edge 2 of RUN → next cycle shows busy=0, done=0, d=0, bo=0, v=0, and no done pulse follows.
